slave_arbiter: RTL and testbench

Per-slave round-robin arbiter and request multiplexer of the crossbar. It sits downstream of the N master-side interface blocks and receives their req/addr/wdata/cmd buses. It grants the slave port to one master at a time and drives the one-hot connect_approved back to those blocks. It forwards the granted master's request to the slave and routes ack/rdata back to the granted master only.

---
 rtl/crossbar_pkg.sv | 19 +
 rtl/slave_arbiter_rr_picker.sv | 31 +++
 rtl/slave_arbiter.sv | 144 ++++++++++++++
 tb/tb_slave_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/crossbar_pkg.sv
// Shared crossbar types and defaults.
// Arbiter states plus default widths and watchdog limit.
package crossbar_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_t;

  localparam int DEF_N_MASTERS = 4;
  localparam int DEF_ADDR_W    = 32;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_TIMEOUT   = 255;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/slave_arbiter_rr_picker.sv
// Round-robin priority encoder: first set request at or after the pointer.
// Pure combinational; scans with wrap-around modulo N.
module rr_picker
  import crossbar_pkg::*;
#(
  parameter int N     = DEF_N_MASTERS,
  parameter int IDX_W = idx_width(DEF_N_MASTERS)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx
);

  // Scan from the farthest offset down so the nearest requester wins.
  always_comb begin
    int j;
    j       = 0;
    o_valid = 1'b0;
    o_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(i_ptr) + k;
      if (j >= N) j = j - N;
      if (i_req[j]) begin
        o_valid = 1'b1;
        o_idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/slave_arbiter.sv
// Per-slave round-robin arbiter and request mux of the crossbar.
// Optional watchdog release via `define SLAVE_ARB_TIMEOUT_EN.
module slave_arbiter
  import crossbar_pkg::*;
#(
  parameter int N_MASTERS = DEF_N_MASTERS,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_MASTERS-1:0]        req_from_masters,
  input  logic [N_MASTERS*ADDR_W-1:0] addr_from_masters,
  input  logic [N_MASTERS*DATA_W-1:0] wdata_from_masters,
  input  logic [N_MASTERS-1:0]        cmd_from_masters,
  output logic [N_MASTERS-1:0]        connect_approved_to_masters,
  output logic [N_MASTERS-1:0]        ack_to_masters,
  output logic [N_MASTERS*DATA_W-1:0] rdata_to_masters,
  output logic                        req_to_slave,
  output logic [ADDR_W-1:0]           addr_to_slave,
  output logic [DATA_W-1:0]           wdata_to_slave,
  output logic                        cmd_to_slave,
  input  logic                        ack_from_slave,
  input  logic [DATA_W-1:0]           rdata_from_slave
`ifdef SLAVE_ARB_TIMEOUT_EN
  ,
  output logic                        timeout_err
`endif
);

  localparam int IDX_W = idx_width(N_MASTERS);

  arb_state_t           r_state;
  logic [IDX_W-1:0]     r_grant_idx;
  logic [N_MASTERS-1:0] r_grant;
  logic [IDX_W-1:0]     r_rr_ptr;

  logic                 w_busy;
  logic                 w_sel_req;
  logic                 w_pick_valid;
  logic [IDX_W-1:0]     w_pick_idx;
  logic                 w_release;
  logic [IDX_W-1:0]     w_next_ptr;

  rr_picker #(
    .N     (N_MASTERS),
    .IDX_W (IDX_W)
  ) u_picker (
    .i_req   (req_from_masters),
    .i_ptr   (r_rr_ptr),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

  assign w_busy    = (r_state == ARB_BUSY);
  assign w_sel_req = req_from_masters[r_grant_idx];

  assign w_next_ptr =
    (r_grant_idx == IDX_W'(N_MASTERS - 1)) ?
    '0 : r_grant_idx + 1'b1;

`ifdef SLAVE_ARB_TIMEOUT_EN
  logic [15:0] r_cnt;
  logic        r_timeout_err;
  logic        w_done;
  logic        w_to_hit;

  assign w_done      = !w_sel_req || ack_from_slave;
  assign w_to_hit    = (r_cnt == 16'(TIMEOUT - 1));
  assign w_release   = w_done || w_to_hit;
  assign timeout_err = r_timeout_err;
`else
  // Completion and abort both end the transfer.
  assign w_release = !w_sel_req || ack_from_slave;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ARB_IDLE;
      r_grant_idx <= '0;
      r_grant     <= '0;
      r_rr_ptr    <= '0;
`ifdef SLAVE_ARB_TIMEOUT_EN
      r_cnt         <= '0;
      r_timeout_err <= 1'b0;
`endif
    end else begin
`ifdef SLAVE_ARB_TIMEOUT_EN
      r_timeout_err <= 1'b0;
`endif
      unique case (r_state)
        ARB_IDLE: begin
          if (w_pick_valid) begin
            r_grant_idx <= w_pick_idx;
            r_grant     <= N_MASTERS'(1) << w_pick_idx;
            r_state     <= ARB_BUSY;
`ifdef SLAVE_ARB_TIMEOUT_EN
            r_cnt       <= '0;
`endif
          end
        end
        ARB_BUSY: begin
          if (w_release) begin
            r_state  <= ARB_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= w_next_ptr;
`ifdef SLAVE_ARB_TIMEOUT_EN
            r_timeout_err <= !w_done;
`endif
          end
`ifdef SLAVE_ARB_TIMEOUT_EN
          else begin
            r_cnt <= r_cnt + 16'd1;
          end
`endif
        end
      endcase
    end
  end

  assign connect_approved_to_masters = r_grant;

  always_comb begin
    req_to_slave     = 1'b0;
    addr_to_slave    = '0;
    wdata_to_slave   = '0;
    cmd_to_slave     = 1'b0;
    ack_to_masters   = '0;
    rdata_to_masters = '0;
    if (w_busy) begin
      req_to_slave   = w_sel_req;
      addr_to_slave  =
        addr_from_masters[int'(r_grant_idx)*ADDR_W +: ADDR_W];
      wdata_to_slave =
        wdata_from_masters[int'(r_grant_idx)*DATA_W +: DATA_W];
      cmd_to_slave   = cmd_from_masters[r_grant_idx];
      ack_to_masters[r_grant_idx] = ack_from_slave;
      rdata_to_masters[int'(r_grant_idx)*DATA_W +: DATA_W] =
        rdata_from_slave;
    end
  end

endmodule

// File: tb/tb_slave_arbiter.sv
// Self-checking bench for slave_arbiter: directed steps plus random phase.
// Reference model tracks owner/pointer with plain integers.
module tb_slave_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]  cmd;
  logic [N-1:0]  conn;
  logic [N-1:0]  ack_m;
  logic [N*DW-1:0] rdata_m;
  logic          req_s;
  logic [AW-1:0] addr_s;
  logic [DW-1:0] wdata_s;
  logic          cmd_s;
  logic          ack_s;
  logic [DW-1:0] rdata_s;
`ifdef SLAVE_ARB_TIMEOUT_EN
  logic          terr;
`endif

  int passed = 0;
  int total  = 0;
  int m_owner, m_ptr, m_cnt;
  bit m_terr;
  int gq[$];

  always #5 clk = ~clk;

  slave_arbiter #(
    .N_MASTERS (N),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .TIMEOUT   (TO)
  ) dut (
    .clk                         (clk),
    .rst                         (rst),
    .req_from_masters            (req),
    .addr_from_masters           (addr),
    .wdata_from_masters          (wdata),
    .cmd_from_masters            (cmd),
    .connect_approved_to_masters (conn),
    .ack_to_masters              (ack_m),
    .rdata_to_masters            (rdata_m),
    .req_to_slave                (req_s),
    .addr_to_slave               (addr_s),
    .wdata_to_slave              (wdata_s),
    .cmd_to_slave                (cmd_s),
    .ack_from_slave              (ack_s),
    .rdata_from_slave            (rdata_s)
`ifdef SLAVE_ARB_TIMEOUT_EN
    ,
    .timeout_err                 (terr)
`endif
  );

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_outputs();
    logic [N-1:0]    e_conn, e_ack;
    logic [N*DW-1:0] e_rd;
    logic            e_req, e_cmd;
    logic [AW-1:0]   e_addr;
    logic [DW-1:0]   e_wd;
    e_conn = '0; e_ack = '0; e_rd = '0;
    e_req = 0; e_cmd = 0; e_addr = '0; e_wd = '0;
    if (m_owner >= 0) begin
      e_conn[m_owner] = 1'b1;
      e_ack[m_owner]  = ack_s;
      e_rd[m_owner*DW +: DW] = rdata_s;
      e_req  = req[m_owner];
      e_cmd  = cmd[m_owner];
      e_addr = addr[m_owner*AW +: AW];
      e_wd   = wdata[m_owner*DW +: DW];
    end
    chk("conn", 128'(conn), 128'(e_conn));
    chk("ack_m", 128'(ack_m), 128'(e_ack));
    chk("rdata_m", 128'(rdata_m), 128'(e_rd));
    chk("req_s", 128'(req_s), 128'(e_req));
    chk("cmd_s", 128'(cmd_s), 128'(e_cmd));
    chk("addr_s", 128'(addr_s), 128'(e_addr));
    chk("wdata_s", 128'(wdata_s), 128'(e_wd));
`ifdef SLAVE_ARB_TIMEOUT_EN
    chk("terr", 128'(terr), 128'(m_terr));
`endif
  endtask

  task automatic model_edge();
    bit nt;
    nt = 0;
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_cnt = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        if (m_owner < 0 && req[(m_ptr + k) % N]) begin
          m_owner = (m_ptr + k) % N;
          m_cnt = 0;
        end
      end
    end else if (!req[m_owner] || ack_s) begin
      m_ptr = (m_owner + 1) % N;
      m_owner = -1;
    end
`ifdef SLAVE_ARB_TIMEOUT_EN
    else if (m_cnt == TO - 1) begin
      m_ptr = (m_owner + 1) % N;
      m_owner = -1;
      nt = 1;
    end else begin
      m_cnt++;
    end
`endif
    m_terr = nt;
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic int onehot_idx(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  initial begin
    int n, b, t;
    logic [127:0] exp_rd;
    m_owner = -1; m_ptr = 0; m_cnt = 0; m_terr = 0;
    rst = 1; req = 4'b1111; cmd = '0; ack_s = 0;
    rdata_s = '0;
    for (int i = 0; i < N; i++) begin
      addr[i*AW +: AW]  = $urandom;
      wdata[i*DW +: DW] = $urandom;
    end
    #2;
    chk("reset_conn", 128'(conn), 128'(0));
    chk("reset_req_s", 128'(req_s), 128'(0));
    cycle();
    cycle();
    rst = 0;
    cycle();
    chk("first_grant", 128'(conn), 128'(4'b0001));

    req = 4'b0010; ack_s = 1;
    cycle();
    ack_s = 0;
    cycle();
    ack_s = 1;
    cycle();
    ack_s = 0; req = 4'b1010;
    addr[3*AW +: AW] = 32'hA000_0010;
    cycle();
    chk("rr_m3_grant", 128'(conn), 128'(4'b1000));
    chk("rr_m3_addr", 128'(addr_s), 128'(32'hA000_0010));
    ack_s = 1; req = 4'b1000;
    cycle();
    ack_s = 0; req = '0;
    cycle();

    req = 4'b1111;
    for (int i = 0; i < 12; i++) begin
      ack_s = (m_owner >= 0);
      cycle();
      if (conn != '0) gq.push_back(onehot_idx(conn));
    end
    chk("order_len_ok", 128'(gq.size() >= 5), 128'(1));
    for (int i = 0; i < 5; i++) begin
      t = (i < gq.size()) ? gq[i] : -1;
      chk("order", 128'(t), 128'(i % N));
    end
    req = '0; ack_s = 0;
    cycle();
    cycle();

    req = 4'b0100; cmd = 4'b0000;
    addr[2*AW +: AW] = 32'h0000_0040;
    n = 0;
    while (m_owner != 2 && n < 6) begin
      cycle();
      n++;
    end
    chk("m2_granted", 128'(conn), 128'(4'b0100));
    ack_s = 1; rdata_s = 32'hDEAD_BEEF;
    #1;
    exp_rd = 128'h0;
    exp_rd[64 +: 32] = 32'hDEAD_BEEF;
    chk("m2_ack", 128'(ack_m), 128'(4'b0100));
    chk("m2_rdata", 128'(rdata_m), exp_rd);
    chk("m2_addr", 128'(addr_s), 128'(32'h40));
    chk("m2_cmd", 128'(cmd_s), 128'(0));
    cycle();
    ack_s = 0; req = '0;
    cycle();

    req = 4'b1000;
    cycle();
    ack_s = 1;
    cycle();
    ack_s = 0; req = 4'b0001;
    cycle();
    chk("abort_m0_grant", 128'(conn), 128'(4'b0001));
    req = 4'b0010;
    cycle();
    chk("abort_cleared", 128'(conn), 128'(0));
    cycle();
    chk("abort_m1_next", 128'(conn), 128'(4'b0010));

    rst = 1;
    m_owner = -1; m_ptr = 0; m_cnt = 0; m_terr = 0;
    #1;
    chk("midrst_conn", 128'(conn), 128'(0));
    chk("midrst_req_s", 128'(req_s), 128'(0));
    cycle();
    rst = 0; req = '0;
    cycle();

`ifdef SLAVE_ARB_TIMEOUT_EN
    req = 4'b0001; ack_s = 0;
    b = 0; t = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (terr) t++;
      if (t == 0 && conn != '0) b++;
    end
    chk("to_busy_cycles", 128'(b), 128'(TO));
    chk("to_pulses", 128'(t), 128'(1));
    req = '0;
    cycle();
    cycle();
`endif

    for (int i = 0; i < 400; i++) begin
      req   = N'($urandom);
      cmd   = N'($urandom);
      ack_s = ($urandom_range(0, 2) == 0);
      rdata_s = $urandom;
      for (int k = 0; k < N; k++) begin
        addr[k*AW +: AW]  = $urandom;
        wdata[k*DW +: DW] = $urandom;
      end
      if ($urandom_range(0, 99) == 0) begin
        rst = 1;
        m_owner = -1; m_ptr = 0; m_cnt = 0; m_terr = 0;
      end else begin
        rst = 0;
      end
      cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
